// File: rtl/mips_mem_arbiter.sv
// -----------------------------------------------------------------------------
// mips_mem_arbiter
//   Shares one single-port synchronous memory between two requesters:
//   port 0 is the multicycle CPU, port 1 is the program loader / debug port.
//   Only one transaction is in flight at a time. When both ports request at
//   once, the grant goes to the port that did not win last time.
//
//   Handshake: a requester raises reqN with weN/addrN/wdataN stable and keeps
//   reqN high until it sees the one-cycle ackN pulse. The command is captured
//   on the granting edge, so later changes to weN/addrN/wdataN are ignored.
//   Dropping reqN mid-transaction does not cancel it: ackN still pulses once.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   req0/1, we0/1     request and write flag of each port
//   addr0/1, wdata0/1 request address and write data
//   ack0/1            one-cycle completion pulse
//   rdata0/1          read data; live with a read ack, then held until the
//                     next read ack to the same port
//   mem_addr/wdata/we memory command, valid while a transaction is active
//   mem_rdata         memory read data, RD_LAT cycles after the address cycle
//   busy, owner       FSM not idle / port currently granted
// -----------------------------------------------------------------------------
module mips_mem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int RD_LAT = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              ack0,
   output logic              ack1,
   output logic [DATA_W-1:0] rdata0,
   output logic [DATA_W-1:0] rdata1,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic              owner
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_WAIT   = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic              owner_q, owner_d;
   logic              last_grant_q, last_grant_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [2:0]        cnt_q, cnt_d;
   logic [DATA_W-1:0] hold0_q, hold0_d;
   logic [DATA_W-1:0] hold1_q, hold1_d;
   logic              grant;

   // State register. last_grant resets to 1 so port 0 wins the first tie.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         owner_q      <= 1'b0;
         last_grant_q <= 1'b1;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         cnt_q        <= 3'd0;
         hold0_q      <= '0;
         hold1_q      <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         cnt_q        <= cnt_d;
         hold0_q      <= hold0_d;
         hold1_q      <= hold1_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      cnt_d        = cnt_q;
      hold0_d      = hold0_q;
      hold1_d      = hold1_q;
      grant        = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req0 || req1) begin
               // A lone requester wins outright; a tie goes to the other port.
               grant        = (req0 && req1) ? ~last_grant_q : req1;
               owner_d      = grant;
               last_grant_d = grant;
               we_d         = grant ? we1    : we0;
               addr_d       = grant ? addr1  : addr0;
               wdata_d      = grant ? wdata1 : wdata0;
               state_d      = S_ACCESS;
            end
         end
         S_ACCESS: begin
            if (we_q || (RD_LAT == 1)) begin
               state_d = S_DONE;
            end else begin
               state_d = S_WAIT;
               cnt_d   = 3'(RD_LAT - 1);
            end
         end
         S_WAIT: begin
            if (cnt_q == 3'd1) begin
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            // Read data is valid only in this cycle; keep it for the owner.
            if (!we_q) begin
               if (owner_q) hold1_d = mem_rdata;
               else         hold0_d = mem_rdata;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Output logic.
   always_comb begin
      ack0      = 1'b0;
      ack1      = 1'b0;
      rdata0    = hold0_q;
      rdata1    = hold1_q;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_we    = 1'b0;
      busy      = (state_q != S_IDLE);
      owner     = owner_q;
      case (state_q)
         S_ACCESS: begin
            mem_addr  = addr_q;
            mem_wdata = wdata_q;
            mem_we    = we_q;
         end
         S_WAIT: begin
            mem_addr = addr_q;
         end
         S_DONE: begin
            mem_addr = addr_q;
            if (owner_q) ack1 = 1'b1;
            else         ack0 = 1'b1;
            // Reads hand memory data straight through in the ack cycle.
            if (!we_q) begin
               if (owner_q) rdata1 = mem_rdata;
               else         rdata0 = mem_rdata;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mips_mem_arbiter
//   Bench for mips_mem_arbiter. Main instance uses RD_LAT=2 behind a small
//   memory model; a second instance uses RD_LAT=1 for the short-latency case.
// -----------------------------------------------------------------------------
module tb_mips_mem_arbiter;

   localparam int AW     = 32;
   localparam int DW     = 32;
   localparam int RD_LAT = 2;

   // ---------------- clock / reset ----------------
   logic clk;
   logic rst_n;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- main DUT signals ----------------
   logic          req0, req1, we0, we1;
   logic [AW-1:0] addr0, addr1;
   logic [DW-1:0] wdata0, wdata1;
   logic          ack0, ack1;
   logic [DW-1:0] rdata0, rdata1;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_we;
   logic [DW-1:0] mem_rdata;
   logic          busy, owner;

   mips_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RD_LAT)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
      .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
   );

   // Memory model: 256 words indexed by the low address byte, RD_LAT pipe.
   logic          mem_load;
   logic [DW-1:0] mem [256];
   logic [DW-1:0] rd_pipe [RD_LAT];

   always @(posedge clk) begin
      if (mem_load) begin
         for (int i = 0; i < 256; i++)
            mem[i] <= (i == 16) ? 32'hDEADBEEF : 32'h1000_0000 + 32'(i);
      end else if (mem_we) begin
         mem[mem_addr[7:0]] <= mem_wdata;
      end
      rd_pipe[0] <= mem[mem_addr[7:0]];
      for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign mem_rdata = rd_pipe[RD_LAT-1];

   // ---------------- RD_LAT=1 instance ----------------
   logic          l1_req0;
   logic [AW-1:0] l1_addr0;
   logic          l1_ack0, l1_ack1;
   logic [DW-1:0] l1_rdata0, l1_rdata1;
   logic [AW-1:0] l1_mem_addr;
   logic [DW-1:0] l1_mem_wdata;
   logic          l1_mem_we;
   logic [DW-1:0] l1_mem_rdata;
   logic          l1_busy, l1_owner;

   mips_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) u_dut_l1 (
      .clk(clk), .rst_n(rst_n),
      .req0(l1_req0), .req1(1'b0), .we0(1'b0), .we1(1'b0),
      .addr0(l1_addr0), .addr1('0), .wdata0('0), .wdata1('0),
      .ack0(l1_ack0), .ack1(l1_ack1), .rdata0(l1_rdata0), .rdata1(l1_rdata1),
      .mem_addr(l1_mem_addr), .mem_wdata(l1_mem_wdata), .mem_we(l1_mem_we),
      .mem_rdata(l1_mem_rdata), .busy(l1_busy), .owner(l1_owner)
   );

   // One-cycle memory whose content is a fixed function of the address.
   always @(posedge clk) l1_mem_rdata <= l1_mem_addr ^ 32'hCAFE_0000;

   // ---------------- checking ----------------
   int n_chk  = 0;
   int n_fail = 0;
   logic [DW-1:0] exp_q0[$];
   logic [DW-1:0] exp_q1[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard: each ack pops the expected rdata of that port.
   always @(negedge clk) begin
      if (rst_n) begin
         if (ack0 && ack1) chk("ack_coincide", 64'(ack0 & ack1), 64'd0);
         if (ack0) begin
            if (exp_q0.size() == 0) chk("sb_unexpected_ack0", 64'(ack0), 64'd0);
            else                    chk("sb_rdata0", 64'(rdata0), 64'(exp_q0.pop_front()));
         end
         if (ack1) begin
            if (exp_q1.size() == 0) chk("sb_unexpected_ack1", 64'(ack1), 64'd0);
            else                    chk("sb_rdata1", 64'(rdata1), 64'(exp_q1.pop_front()));
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // One transaction on an otherwise idle arbiter; checks ack latency.
   task automatic do_txn(input int p, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [DW-1:0] exp_rd,
                         input int exp_lat, input string name);
      int n;
      logic got;
      repeat ($urandom_range(0, 2)) @(posedge clk);
      @(posedge clk);
      #1;
      if (p == 0) begin
         req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; exp_q0.push_back(exp_rd);
      end else begin
         req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; exp_q1.push_back(exp_rd);
      end
      n   = 0;
      got = 1'b0;
      while (!got && n <= 40) begin
         @(negedge clk);
         got = (p == 0) ? ack0 : ack1;
         if (!got) n++;
      end
      if (got) chk({name, "_latency"}, 64'(n), 64'(exp_lat));
      else     chk({name, "_timeout"}, 64'(got), 64'd1);
      if (p == 0) begin req0 = 1'b0; addr0 = $urandom; wdata0 = $urandom; end
      else        begin req1 = 1'b0; addr1 = $urandom; wdata1 = $urandom; end
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      int            port;
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [DW-1:0] exp_rd;   // rdata at ack: read data, or held value for writes
      int            exp_lat;
   } vec_t;

   vec_t vecs[12];

   // ---------------- main sequence ----------------
   initial begin
      int cnt_ack;
      int cnt_rise;
      logic prev_busy;

      vecs[0]  = '{0, 1'b1, 32'h40, 32'hA1B2C3D4, 32'h12345678, 2};
      vecs[1]  = '{0, 1'b0, 32'h40, 32'h0,        32'hA1B2C3D4, 3};
      vecs[2]  = '{1, 1'b0, 32'h40, 32'h0,        32'hA1B2C3D4, 3};
      vecs[3]  = '{1, 1'b1, 32'h44, 32'h55AA55AA, 32'hA1B2C3D4, 2};
      vecs[4]  = '{0, 1'b0, 32'h44, 32'h0,        32'h55AA55AA, 3};
      vecs[5]  = '{1, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 3};
      vecs[6]  = '{0, 1'b1, 32'h10, 32'h0,        32'h55AA55AA, 2};
      vecs[7]  = '{1, 1'b0, 32'h10, 32'h0,        32'h00000000, 3};
      vecs[8]  = '{0, 1'b0, 32'h80, 32'h0,        32'h10000080, 3};
      vecs[9]  = '{1, 1'b0, 32'hFF, 32'h0,        32'h100000FF, 3};
      vecs[10] = '{1, 1'b1, 32'h80, 32'hFFFFFFFF, 32'h100000FF, 2};
      vecs[11] = '{0, 1'b0, 32'h80, 32'h0,        32'hFFFFFFFF, 3};

      rst_n = 1'b0; mem_load = 1'b1;
      req0 = 0; req1 = 0; we0 = 0; we1 = 0;
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
      l1_req0 = 0; l1_addr0 = '0;

      // Reset values
      @(negedge clk);
      chk("rst_ack0", 64'(ack0), 64'd0);
      chk("rst_ack1", 64'(ack1), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_owner", 64'(owner), 64'd0);
      chk("rst_mem_we", 64'(mem_we), 64'd0);
      chk("rst_mem_addr", 64'(mem_addr), 64'd0);
      chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
      chk("rst_rdata0", 64'(rdata0), 64'd0);
      chk("rst_rdata1", 64'(rdata1), 64'd0);
      @(posedge clk); #1 mem_load = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;

      // Read 0x10 by port 0: address held cycles 1-3, ack at 3, data held.
      @(posedge clk); #1;
      req0 = 1; we0 = 0; addr0 = 32'h10;
      exp_q0.push_back(32'hDEADBEEF);
      for (int c = 0; c <= 10; c++) begin
         @(negedge clk);
         chk($sformatf("t1_mem_addr_c%0d", c), 64'(mem_addr),
             (c >= 1 && c <= 3) ? 64'h10 : 64'h0);
         chk($sformatf("t1_ack0_c%0d", c), 64'(ack0), (c == 3) ? 64'd1 : 64'd0);
         chk($sformatf("t1_mem_we_c%0d", c), 64'(mem_we), 64'd0);
         if (c == 3) begin
            chk("t1_rdata0_ack", 64'(rdata0), 64'hDEADBEEF);
            req0 = 0;
         end
         if (c == 10) chk("t1_rdata0_held", 64'(rdata0), 64'hDEADBEEF);
      end

      // Write by port 1: mem_we only in cycle 1, ack at 2, command captured.
      @(posedge clk); #1;
      req1 = 1; we1 = 1; addr1 = 32'h20; wdata1 = 32'h12345678;
      exp_q1.push_back(32'h0);
      for (int c = 0; c <= 4; c++) begin
         @(negedge clk);
         if (c == 1) begin
            addr1 = 32'h3C; wdata1 = 32'hBAD0BAD0; we1 = 0;
            chk("t2_mem_addr", 64'(mem_addr), 64'h20);
            chk("t2_mem_wdata", 64'(mem_wdata), 64'h12345678);
         end
         chk($sformatf("t2_mem_we_c%0d", c), 64'(mem_we), (c == 1) ? 64'd1 : 64'd0);
         chk($sformatf("t2_ack1_c%0d", c), 64'(ack1), (c == 2) ? 64'd1 : 64'd0);
         if (c == 2) req1 = 0;
      end
      chk("t2_mem_content", 64'(mem[8'h20]), 64'h12345678);
      chk("t2_mem_3c_untouched", 64'(mem[8'h3C]), 64'h1000003C);
      do_txn(0, 1'b0, 32'h20, 32'h0, 32'h12345678, 3, "t2_readback");

      // Table-driven single transactions
      for (int i = 0; i < 12; i++)
         do_txn(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                vecs[i].exp_rd, vecs[i].exp_lat, $sformatf("vec%0d", i));

      // req0 dropped during WAIT: one ack, no second access.
      @(posedge clk); #1;
      req0 = 1; we0 = 0; addr0 = 32'h44;
      exp_q0.push_back(32'h55AA55AA);
      cnt_ack = 0; cnt_rise = 0; prev_busy = 1'b0;
      for (int c = 0; c <= 12; c++) begin
         @(negedge clk);
         if (ack0) begin
            cnt_ack++;
            chk("t5_ack_cycle", 64'(c), 64'd3);
         end
         if (busy && !prev_busy) cnt_rise++;
         prev_busy = busy;
         if (c == 2) req0 = 0;
      end
      chk("t5_ack_count", 64'(cnt_ack), 64'd1);
      chk("t5_access_count", 64'(cnt_rise), 64'd1);

      // Both ports held from reset: grants alternate 0,1,0,1.
      we0 = 0; addr0 = 32'h40; we1 = 0; addr1 = 32'h80;
      exp_q0.push_back(32'hA1B2C3D4); exp_q0.push_back(32'hA1B2C3D4);
      exp_q1.push_back(32'hFFFFFFFF); exp_q1.push_back(32'hFFFFFFFF);
      do_reset();
      req0 = 1; req1 = 1;
      for (int c = 0; c <= 19; c++) begin
         @(negedge clk);
         chk($sformatf("t3_ack0_c%0d", c), 64'(ack0), (c == 3 || c == 11) ? 64'd1 : 64'd0);
         chk($sformatf("t3_ack1_c%0d", c), 64'(ack1), (c == 7 || c == 15) ? 64'd1 : 64'd0);
         if (c == 1) chk("t3_owner_first", 64'(owner), 64'd0);
         if (c == 5) chk("t3_owner_second", 64'(owner), 64'd1);
         if (c == 4 || c == 8) chk($sformatf("t3_bubble_c%0d", c), 64'(busy), 64'd0);
         if (c == 15) begin req0 = 0; req1 = 0; end
      end

      // Reset during WAIT of a read abandons it.
      @(posedge clk); #1;
      req0 = 1; we0 = 0; addr0 = 32'h10;
      for (int c = 0; c <= 2; c++) @(negedge clk);
      chk("t4_busy_before", 64'(busy), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("t4_ack0", 64'(ack0), 64'd0);
      chk("t4_busy", 64'(busy), 64'd0);
      chk("t4_mem_we", 64'(mem_we), 64'd0);
      chk("t4_mem_addr", 64'(mem_addr), 64'd0);
      chk("t4_rdata0", 64'(rdata0), 64'd0);
      req0 = 0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("t4_idle_after", 64'(busy), 64'd0);
      do_txn(0, 1'b0, 32'h44, 32'h0, 32'h55AA55AA, 3, "t4_after_reset");

      // RD_LAT=1 instance: read ack two cycles after request.
      @(posedge clk); #1;
      l1_req0 = 1; l1_addr0 = 32'h30;
      for (int c = 0; c <= 3; c++) begin
         @(negedge clk);
         chk($sformatf("t6_ack0_c%0d", c), 64'(l1_ack0), (c == 2) ? 64'd1 : 64'd0);
         if (c == 1) chk("t6_mem_addr", 64'(l1_mem_addr), 64'h30);
         if (c == 2) begin
            chk("t6_rdata0", 64'(l1_rdata0), 64'hCAFE0030);
            l1_req0 = 0;
         end
         if (c == 3) chk("t6_rdata0_held", 64'(l1_rdata0), 64'hCAFE0030);
      end

      repeat (3) @(posedge clk);
      chk("sb_q0_empty", 64'(exp_q0.size()), 64'd0);
      chk("sb_q1_empty", 64'(exp_q1.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   // Global time limit
   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached before end of test");
      $fatal(1, "time limit reached");
   end

endmodule
